sweep_ctrl: RTL and testbench
=============================

# sweep_ctrl

Sequencer for the signal generator's address counter path: takes a one-cycle start command with a base address, step, pass length and repeat count, then issues a gated stream of ROM addresses, one per sample-enable tick, wrapping back to base at the end of every pass. It sits between the prescaler/tick source and the waveform ROM, replacing the free-running counter when bounded, strided or repeated sweeps are required. Status is reported by busy, a per-pass pulse and a completion pulse.

## Interface

- WIDTH, 9: address width; all address arithmetic is modulo 2^WIDTH.
- LEN_W, 9: width of the per-pass sample count.
- REP_W, 4: width of the pass repeat count.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  command pulse; accepted only in IDLE with len != 0.
- abort  in  1  stop request; honoured in RUN only.
- en  in  1  sample-enable tick from prescaler.
- base  in  WIDTH  first address of each pass; latched at start.
- step  in  WIDTH  address increment per sample; latched at start; 0 is legal (constant address).
- len  in  LEN_W  samples per pass; latched at start; 0 means start is ignored.
- reps  in  REP_W  passes to run; latched at start; 0 means run until abort.
- addr  out  WIDTH  current ROM address (registered).
- addr_vld  out  1  addr is a sample this cycle; equals en while in RUN.
- busy  out  1  high in RUN.
- pass_end  out  1  one-cycle pulse on the last sample of each pass.
- done  out  1  one-cycle pulse on normal completion (not on abort).

## Operation

- States: IDLE, RUN, DONE.
- IDLE: on start && len != 0, latch base/step/len/reps, load addr <= base, clear sample count and pass count, go to RUN. start with len == 0 leaves state unchanged.
- RUN, per cycle with en = 1 (sample consumed):
  - if sample count == len-1 (last sample of pass): assert pass_end in the same cycle as addr_vld; addr <= base; sample count <= 0; if reps != 0 and pass count == reps-1 go to DONE, else pass count <= pass count + 1 (pass count wraps mod 2^REP_W when reps == 0).
  - otherwise addr <= addr + step, truncated to WIDTH bits; sample count +1.
- RUN with en = 0: all registers hold.
- abort in RUN: go to IDLE next edge; no done and no pass_end. If abort and en coincide, the sample in that cycle is still presented (addr_vld = 1) but no counter or pass_end side effects occur.
- DONE: done = 1 for exactly one cycle, busy = 0, then IDLE. start during DONE is ignored.
- start while busy: ignored; latched configuration never changes mid-run.
- Changes on base/step/len/reps outside a start cycle have no effect.

## Timing

- Reset (async assert): state IDLE; addr = 0; busy, addr_vld, pass_end, done = 0; counters 0. Deassertion is synchronous to clk by the upstream reset scheme. Reset mid-run aborts immediately with no done.
- start accepted at edge N: busy = 1 and addr = base from N+1; earliest sample is a cycle N+1 with en = 1.
- addr_vld and pass_end are combinational from en and registered state (zero latency); addr advances at the edge ending a valid sample.
- A complete run with en held high lasts len*reps cycles in RUN, then 1 DONE cycle; busy falls when done rises.
- Back-to-back: start may be accepted the cycle after done (state IDLE).
- Address wrap: base + k*step overflows silently mod 2^WIDTH.

## Test plan

- Reset mid-run: assert rst during RUN with en high -> addr = 0, busy = 0, done never pulses, outputs stay 0 while rst is high.
- Basic run: base=10, step=3, len=4, reps=2, en always 1 -> addr sequence 10,13,16,19,10,13,16,19; pass_end on the 4th and 8th samples; done one cycle after the 8th sample; busy high for exactly 8 cycles.
- Wrap and gating: WIDTH=9, base=510, step=1, len=4, reps=1, en high every 3rd cycle -> addr_vld only on en cycles; samples 510,511,0,1; addr holds between ticks.
- Continuous and abort: reps=0, len=2, base=0, step=5 -> repeating 0,5; raise abort after 7 samples -> busy falls next cycle, no done; a later start runs normally.
- Ignored starts: start with len=0 in IDLE -> stays IDLE; start pulsed in RUN with different base -> sequence is unchanged.
- step=0 and coincident abort/en: step=0, base=42 -> every sample is 42; abort with en=1 -> that sample is presented, with no pass_end.

Source files
------------

// File: rtl/sweep_ctrl.sv
// Bounded, strided, repeatable ROM address sweeper. It latches a sweep
// configuration on start and emits one address per sample-enable tick.
module sweep_ctrl #(
  parameter int WIDTH = 9,
  parameter int LEN_W = 9,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             en,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] step,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic [WIDTH-1:0] addr,
  output logic             addr_vld,
  output logic             busy,
  output logic             pass_end,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, nxt;

  logic [WIDTH-1:0] base_q, step_q;
  logic [LEN_W-1:0] len_q, scnt;
  logic [REP_W-1:0] reps_q, pcnt;
  logic             accept, take, last_smp, final_pass;

  // A sample only advances counters when it is not being aborted.
  assign accept     = (state == IDLE) && start && (len != '0);
  assign take       = (state == RUN) && en && !abort;
  assign last_smp   = (scnt == len_q - LEN_W'(1));
  assign final_pass = (reps_q != '0) && (pcnt == reps_q - REP_W'(1));

  assign busy     = (state == RUN);
  assign addr_vld = busy && en;
  assign pass_end = take && last_smp;
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = RUN;
      RUN: begin
        if (abort)                                nxt = IDLE;
        else if (en && last_smp && final_pass)    nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: configuration latch plus address and pass/sample counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      step_q <= '0;
      len_q  <= '0;
      reps_q <= '0;
      addr   <= '0;
      scnt   <= '0;
      pcnt   <= '0;
    end else if (accept) begin
      base_q <= base;
      step_q <= step;
      len_q  <= len;
      reps_q <= reps;
      addr   <= base;
      scnt   <= '0;
      pcnt   <= '0;
    end else if (take) begin
      if (last_smp) begin
        addr <= base_q;
        scnt <= '0;
        if (!final_pass) pcnt <= pcnt + REP_W'(1);
      end else begin
        addr <= addr + step_q;
        scnt <= scnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed self-checking bench for sweep_ctrl: inputs change on the falling
// edge and outputs are sampled 1ns later, well away from the rising edge.
module tb_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, en;
  logic [8:0] base, step;
  logic [8:0] len;
  logic [3:0] reps;
  logic [8:0] addr;
  logic       addr_vld, busy, pass_end, done;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sweep_ctrl #(.WIDTH(9), .LEN_W(9), .REP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en),
    .base(base), .step(step), .len(len), .reps(reps),
    .addr(addr), .addr_vld(addr_vld), .busy(busy),
    .pass_end(pass_end), .done(done)
  );

  // Pulse start with a configuration for one cycle; en stays low.
  task automatic launch(input int b, input int s, input int l, input int r);
    @(negedge clk);
    start = 1'b1; abort = 1'b0; en = 1'b0;
    base = 9'(b); step = 9'(s); len = 9'(l); reps = 4'(r);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; abort = 0; en = 0; base = 0; step = 0; len = 0; reps = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (addr !== 9'd0) $display("[TB] FAIL reset_addr got %0d want 0", addr); else passes++;
    checks++; if ({busy, addr_vld, pass_end, done} !== 4'b0) $display("[TB] FAIL reset_flags got %b want 0000", {busy, addr_vld, pass_end, done}); else passes++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_idle_busy got %b want 0", busy); else passes++;
  endtask

  task automatic test_basic;
    int exp_a[8] = '{10, 13, 16, 19, 10, 13, 16, 19};
    launch(10, 3, 4, 2);
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (addr !== 9'(exp_a[k])) $display("[TB] FAIL basic_addr k=%0d got %0d want %0d", k, addr, exp_a[k]); else passes++;
      checks++; if ({busy, addr_vld, done} !== 3'b110) $display("[TB] FAIL basic_flags k=%0d got %b want 110", k, {busy, addr_vld, done}); else passes++;
      checks++; if (pass_end !== (k == 3 || k == 7)) $display("[TB] FAIL basic_pass_end k=%0d got %b want %b", k, pass_end, (k == 3 || k == 7)); else passes++;
    end
    @(negedge clk); #1;
    checks++; if ({done, busy, addr_vld} !== 3'b100) $display("[TB] FAIL basic_done got %b want 100", {done, busy, addr_vld}); else passes++;
    en = 1'b0;
    @(negedge clk); #1;
    checks++; if ({done, busy} !== 2'b00) $display("[TB] FAIL basic_after_done got %b want 00", {done, busy}); else passes++;
  endtask

  task automatic test_wrap_gating;
    int exp_a[4] = '{510, 511, 0, 1};
    int s = 0;
    launch(510, 1, 4, 1);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      en = (c % 3 == 2);
      #1;
      checks++; if (addr !== 9'(exp_a[s])) $display("[TB] FAIL wrap_addr c=%0d got %0d want %0d", c, addr, exp_a[s]); else passes++;
      checks++; if (addr_vld !== en) $display("[TB] FAIL wrap_vld c=%0d got %b want %b", c, addr_vld, en); else passes++;
      checks++; if (pass_end !== (en && s == 3)) $display("[TB] FAIL wrap_pass_end c=%0d got %b want %b", c, pass_end, (en && s == 3)); else passes++;
      if (en) s++;
    end
    @(negedge clk); en = 1'b0; #1;
    checks++; if (done !== 1'b1) $display("[TB] FAIL wrap_done got %b want 1", done); else passes++;
  endtask

  task automatic test_continuous_abort;
    int exp_a[7] = '{0, 5, 0, 5, 0, 5, 0};
    launch(0, 5, 2, 0);
    en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (addr !== 9'(exp_a[k])) $display("[TB] FAIL cont_addr k=%0d got %0d want %0d", k, addr, exp_a[k]); else passes++;
      checks++; if (pass_end !== (k % 2 == 1)) $display("[TB] FAIL cont_pass_end k=%0d got %b want %b", k, pass_end, (k % 2 == 1)); else passes++;
    end
    @(negedge clk); en = 1'b0; abort = 1'b1; #1;
    checks++; if ({busy, addr} !== {1'b1, 9'd5}) $display("[TB] FAIL cont_abort_cycle got busy=%b addr=%0d want busy=1 addr=5", busy, addr); else passes++;
    @(negedge clk); abort = 1'b0; #1;
    checks++; if ({busy, done} !== 2'b00) $display("[TB] FAIL cont_after_abort got %b want 00", {busy, done}); else passes++;
    @(negedge clk); #1;
    checks++; if (done !== 1'b0) $display("[TB] FAIL cont_no_done got %b want 0", done); else passes++;
    launch(3, 2, 2, 1);
    en = 1'b1; #1;
    checks++; if (addr !== 9'd3) $display("[TB] FAIL cont_restart_a0 got %0d want 3", addr); else passes++;
    @(negedge clk); #1;
    checks++; if ({addr, pass_end} !== {9'd5, 1'b1}) $display("[TB] FAIL cont_restart_a1 got addr=%0d pe=%b want addr=5 pe=1", addr, pass_end); else passes++;
    @(negedge clk); en = 1'b0; #1;
    checks++; if (done !== 1'b1) $display("[TB] FAIL cont_restart_done got %b want 1", done); else passes++;
  endtask

  task automatic test_ignored_starts;
    launch(77, 1, 0, 1);
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL ign_len0 got busy=%b want 0", busy); else passes++;
    launch(20, 1, 3, 1);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      start = (k == 1); base = 9'd99; len = 9'd1; step = 9'd7;
      #1;
      checks++; if (addr !== 9'(20 + k)) $display("[TB] FAIL ign_addr k=%0d got %0d want %0d", k, addr, 20 + k); else passes++;
      checks++; if (pass_end !== (k == 2)) $display("[TB] FAIL ign_pass_end k=%0d got %b want %b", k, pass_end, (k == 2)); else passes++;
    end
    @(negedge clk); start = 1'b0; en = 1'b0; #1;
    checks++; if (done !== 1'b1) $display("[TB] FAIL ign_done got %b want 1", done); else passes++;
  endtask

  task automatic test_back_to_back;
    launch(7, 0, 1, 1);
    en = 1'b1; #1;
    checks++; if ({addr, pass_end} !== {9'd7, 1'b1}) $display("[TB] FAIL b2b_first got addr=%0d pe=%b want 7/1", addr, pass_end); else passes++;
    // start during DONE must be ignored
    @(negedge clk); en = 1'b0; start = 1'b1; base = 9'd200; len = 9'd2; reps = 4'd1; #1;
    checks++; if (done !== 1'b1) $display("[TB] FAIL b2b_done got %b want 1", done); else passes++;
    @(negedge clk); base = 9'd50; step = 9'd1; #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL b2b_idle got busy=%b want 0", busy); else passes++;
    @(negedge clk); start = 1'b0; en = 1'b1; #1;
    checks++; if ({busy, addr} !== {1'b1, 9'd50}) $display("[TB] FAIL b2b_second got busy=%b addr=%0d want 1/50", busy, addr); else passes++;
    @(negedge clk); #1;
    checks++; if ({addr, pass_end} !== {9'd51, 1'b1}) $display("[TB] FAIL b2b_second_last got addr=%0d pe=%b want 51/1", addr, pass_end); else passes++;
    @(negedge clk); en = 1'b0; #1;
    checks++; if (done !== 1'b1) $display("[TB] FAIL b2b_second_done got %b want 1", done); else passes++;
  endtask

  task automatic test_step0_abort;
    launch(42, 0, 3, 2);
    en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (addr !== 9'd42) $display("[TB] FAIL s0_addr k=%0d got %0d want 42", k, addr); else passes++;
    end
    // abort lands on the last sample of the pass: presented, but no pass_end
    @(negedge clk); abort = 1'b1; #1;
    checks++; if ({addr_vld, addr, pass_end} !== {1'b1, 9'd42, 1'b0}) $display("[TB] FAIL s0_abort_sample got vld=%b addr=%0d pe=%b want 1/42/0", addr_vld, addr, pass_end); else passes++;
    @(negedge clk); abort = 1'b0; en = 1'b0; #1;
    checks++; if ({busy, done} !== 2'b00) $display("[TB] FAIL s0_after_abort got %b want 00", {busy, done}); else passes++;
  endtask

  task automatic test_reset_midrun;
    launch(100, 2, 5, 3);
    en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; #1;
    checks++; if (addr !== 9'd0) $display("[TB] FAIL rmid_addr got %0d want 0", addr); else passes++;
    checks++; if ({busy, addr_vld, pass_end, done} !== 4'b0) $display("[TB] FAIL rmid_flags got %b want 0000", {busy, addr_vld, pass_end, done}); else passes++;
    @(negedge clk); #1;
    checks++; if ({busy, addr_vld, done} !== 3'b0) $display("[TB] FAIL rmid_hold got %b want 000", {busy, addr_vld, done}); else passes++;
    rst = 1'b0; en = 1'b0;
    @(negedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) $display("[TB] FAIL rmid_after got %b want 00", {busy, done}); else passes++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap_gating;
    test_continuous_abort;
    test_ignored_starts;
    test_back_to_back;
    test_step0_abort;
    test_reset_midrun;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
